// File: rtl/csm_pkg.sv
// Shared types for the N-port shared-memory controller: error codes, port FSM states
// and the latched command record.
package csm_pkg;

  localparam int unsigned CSM_DATABITS = 8;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_LOCKED  = 2'd1,
    ERR_ILLEGAL = 2'd2,
    ERR_RANGE   = 2'd3
  } err_t;

  typedef logic [1:0] port_state_t;
  localparam port_state_t IDLE = 2'd0;
  localparam port_state_t WDAT = 2'd1;
  localparam port_state_t PEND = 2'd2;

  // release is a language keyword, so the unlock flag is carried as rel
  typedef struct packed {
    logic                    rw;
    logic                    hold;
    logic                    rel;
    logic [CSM_DATABITS-1:0] addr;
    logic [CSM_DATABITS-1:0] data;
  } cmd_t;

endpackage

// File: rtl/csm_rr_arbiter.sv
// One-grant-per-cycle arbiter: rotating priority from last grant + 1, or fixed
// priority with index 0 highest.
module csm_rr_arbiter #(
  parameter int unsigned N       = 4,
  parameter bit          RR_MODE = 1'b1,
  localparam int unsigned IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] gnt_idx_c
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int unsigned   j;

  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    found     = 1'b0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = RR_MODE ? ((32'(ptr_q) + 32'(k) + 32'd1) % N) : 32'(k);
      if (!found && req[IW'(j)]) begin
        found             = 1'b1;
        gnt_c[IW'(j)]     = 1'b1;
        gnt_idx_c         = IW'(j);
      end
    end
    ptr_d = found ? gnt_idx_c : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/csm_nport_ctrl.sv
// N-port shared-memory controller: per-port latched command FSMs, a shared arbiter,
// a hold/release exclusive lock and a single-port RAM.
module csm_nport_ctrl
  import csm_pkg::*;
#(
  parameter int unsigned NPORTS   = 4,
  parameter int unsigned DATABITS = CSM_DATABITS,
  parameter int unsigned ERRBITS  = 2,
  parameter int unsigned DEPTH    = 256,
  parameter bit          RR_MODE  = 1'b1,
  localparam int unsigned IW      = $clog2(NPORTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NPORTS*DATABITS-1:0]   in_AD,
  input  logic [NPORTS-1:0]            rw,
  input  logic [NPORTS-1:0]            enable,
  input  logic [NPORTS-1:0]            hold,
  input  logic [NPORTS-1:0]            release_req,
  output logic [NPORTS-1:0]            ack,
  output logic [NPORTS*ERRBITS-1:0]    err,
  output logic [NPORTS*DATABITS-1:0]   out_data,
  output logic                         lock_vld,
  output logic [IW-1:0]                lock_own
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATABITS-1:0] mem [DEPTH];

  logic [NPORTS-1:0]   req, gnt;
  logic [IW-1:0]       gnt_idx;
  cmd_t [NPORTS-1:0]   cmd_all;
  cmd_t                sel;
  logic [DATABITS-1:0] sel_addr, sel_data, exec_rdata;
  logic [AW-1:0]       mem_idx;
  logic                in_range, other_owns, exec_upd, mem_we;
  err_t                exec_err;
  logic                lock_vld_q, lock_vld_d;
  logic [IW-1:0]       lock_own_q, lock_own_d;

  csm_rr_arbiter #(.N(NPORTS), .RR_MODE(RR_MODE)) u_arb (
    .clk       (clk),
    .rst       (reset),
    .req       (req),
    .gnt_c     (gnt),
    .gnt_idx_c (gnt_idx)
  );

  // Execute the granted command; first matching rule decides the status
  always_comb begin
    sel        = cmd_all[gnt_idx];
    sel_addr   = DATABITS'(sel.addr);
    sel_data   = DATABITS'(sel.data);
    mem_idx    = AW'(sel_addr);
    in_range   = 32'(sel_addr) < DEPTH;
    other_owns = lock_vld_q && (lock_own_q != gnt_idx);
    exec_err   = ERR_OK;
    exec_upd   = 1'b0;
    exec_rdata = '0;
    mem_we     = 1'b0;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    if (|gnt) begin
      if (sel.hold && sel.rel) begin
        exec_err = ERR_ILLEGAL;
      end else if (sel.hold) begin
        if (other_owns) exec_err = ERR_LOCKED;
        else begin
          lock_vld_d = 1'b1;
          lock_own_d = gnt_idx;
        end
      end else if (sel.rel) begin
        if (lock_vld_q && !other_owns) begin
          lock_vld_d = 1'b0;
          lock_own_d = '0;
        end else exec_err = ERR_ILLEGAL;
      end else if (other_owns) begin
        exec_err = ERR_LOCKED;
      end else if (!in_range) begin
        exec_err = ERR_RANGE;
        exec_upd = !sel.rw;
      end else if (!sel.rw) begin
        exec_upd   = 1'b1;
        exec_rdata = mem[mem_idx];
      end else begin
        mem_we = 1'b1;
      end
    end
  end

  // RAM is never cleared; a reset edge suppresses a write in flight
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_idx] <= sel_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
    end
  end

  assign lock_vld = lock_vld_q;
  assign lock_own = lock_own_q;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    port_state_t         state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    logic                ack_q, ack_d;
    err_t                err_q, err_d;
    logic [DATABITS-1:0] rdata_q, rdata_d;
    logic [DATABITS-1:0] ad;

    assign ad = in_AD[i*DATABITS +: DATABITS];

    always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      ack_d   = ack_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
        IDLE: if (enable[i]) begin
          cmd_d.rw   = rw[i];
          cmd_d.hold = hold[i];
          cmd_d.rel  = release_req[i];
          cmd_d.addr = CSM_DATABITS'(ad);
          cmd_d.data = '0;
          ack_d      = 1'b0;
          state_d    = (rw[i] && !hold[i] && !release_req[i]) ? WDAT : PEND;
        end
        WDAT: begin
          cmd_d.data = CSM_DATABITS'(ad);
          state_d    = PEND;
        end
        PEND: if (gnt[i]) begin
          err_d   = exec_err;
          rdata_d = exec_upd ? exec_rdata : rdata_q;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= IDLE;
        cmd_q   <= '0;
        ack_q   <= 1'b1;
        err_q   <= ERR_OK;
        rdata_q <= '0;
      end else begin
        state_q <= state_d;
        cmd_q   <= cmd_d;
        ack_q   <= ack_d;
        err_q   <= err_d;
        rdata_q <= rdata_d;
      end
    end

    assign req[i]                              = (state_q == PEND);
    assign cmd_all[i]                          = cmd_q;
    assign ack[i]                              = ack_q;
    assign err[i*ERRBITS +: ERRBITS]           = ERRBITS'(err_q);
    assign out_data[i*DATABITS +: DATABITS]    = rdata_q;
  end

endmodule

// File: tb/tb_csm_nport_ctrl.sv
// Scoreboard bench for csm_nport_ctrl: stimulus pushes expected completions in grant
// order, a negedge monitor pops one on every ack rising edge and compares.
module tb_csm_nport_ctrl;
  import csm_pkg::*;

  localparam int NP = 4;
  localparam int DB = 8;
  localparam int EB = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*DB-1:0]  in_ad;
  logic [NP-1:0]     rw, en, hold, rel;
  logic [NP-1:0]     ack;
  logic [NP*EB-1:0]  err;
  logic [NP*DB-1:0]  out_data;
  logic              lock_vld;
  logic [1:0]        lock_own;

  typedef struct {
    int         port;
    logic [1:0] err;
    logic [7:0] data;
    bit         chk;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  csm_nport_ctrl #(.NPORTS(NP), .DATABITS(DB), .ERRBITS(EB), .DEPTH(128), .RR_MODE(1'b1)) dut (
    .clk         (clk),
    .reset       (rst),
    .in_AD       (in_ad),
    .rw          (rw),
    .enable      (en),
    .hold        (hold),
    .release_req (rel),
    .ack         (ack),
    .err         (err),
    .out_data    (out_data),
    .lock_vld    (lock_vld),
    .lock_own    (lock_own)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    en   = '0;
    rw   = '0;
    hold = '0;
    rel  = '0;
  endtask

  task automatic cmd(input int p, input bit w, input bit h, input bit r, input logic [7:0] a);
    en[p]            = 1'b1;
    rw[p]            = w;
    hold[p]          = h;
    rel[p]           = r;
    in_ad[p*DB +: DB] = a;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ack !== 4'hF && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ack_idle", 32'(ack), 32'hF);
    @(negedge clk);
    #1;
  endtask

  task automatic op(input int p, input bit w, input bit h, input bit r, input logic [7:0] a,
                    input logic [7:0] d, input logic [1:0] e, input logic [7:0] xd, input bit chk);
    exp_q.push_back('{p, e, xd, chk});
    cmd(p, w, h, r, a);
    step();
    if (w && !h && !r) begin
      in_ad[p*DB +: DB] = d;
      step();
    end
    wait_idle();
  endtask

  // Monitor: every completion (ack rising) must match the next expected entry
  initial begin
    logic [NP-1:0] prev;
    exp_t          e;
    prev = '1;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) prev = '1;
      else begin
        for (int p = 0; p < NP; p++) begin
          if (ack[p] && !prev[p]) begin
            if (exp_q.size() == 0) begin
              check($sformatf("unexpected_completion_p%0d", p), 32'(p), 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("grant_port", 32'(p), 32'(e.port));
              check($sformatf("err_p%0d", p), 32'(err[p*EB +: EB]), 32'(e.err));
              if (e.chk) check($sformatf("data_p%0d", p), 32'(out_data[p*DB +: DB]), 32'(e.data));
            end
          end
        end
        prev = ack;
      end
    end
  end

  initial begin
    rst = 1'b1; in_ad = '0; rw = '0; en = '0; hold = '0; rel = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ack", 32'(ack), 32'hF);
    check("rst_err", 32'(err), 32'h0);
    check("rst_data", out_data, 32'h0);
    check("rst_lock_vld", 32'(lock_vld), 32'h0);
    check("rst_lock_own", 32'(lock_own), 32'h0);

    // Basic write then read from another port
    op(0, 1, 0, 0, 8'h10, 8'hA5, ERR_OK, 8'h00, 0);
    op(1, 0, 0, 0, 8'h10, 8'h00, ERR_OK, 8'hA5, 1);

    // Round-robin bursts; a port3 grant first puts the pointer at 3
    op(0, 1, 0, 0, 8'h01, 8'h11, ERR_OK, 8'h00, 0);
    op(0, 1, 0, 0, 8'h02, 8'h22, ERR_OK, 8'h00, 0);
    op(0, 1, 0, 0, 8'h03, 8'h33, ERR_OK, 8'h00, 0);
    op(3, 0, 0, 0, 8'h10, 8'h00, ERR_OK, 8'hA5, 1);
    for (int rep = 0; rep < 2; rep++) begin
      exp_q.push_back('{0, ERR_OK, 8'hA5, 1'b1});
      exp_q.push_back('{1, ERR_OK, 8'h11, 1'b1});
      exp_q.push_back('{2, ERR_OK, 8'h22, 1'b1});
      exp_q.push_back('{3, ERR_OK, 8'h33, 1'b1});
      cmd(0, 0, 0, 0, 8'h10);
      cmd(1, 0, 0, 0, 8'h01);
      cmd(2, 0, 0, 0, 8'h02);
      cmd(3, 0, 0, 0, 8'h03);
      step();
      wait_idle();
    end

    // Lock behaviour
    op(0, 1, 0, 0, 8'h20, 8'h77, ERR_OK, 8'h00, 0);
    op(2, 0, 1, 0, 8'h00, 8'h00, ERR_OK, 8'h00, 0);
    check("lock_vld_held", 32'(lock_vld), 32'h1);
    check("lock_own_held", 32'(lock_own), 32'h2);
    op(2, 0, 1, 0, 8'h00, 8'h00, ERR_OK, 8'h00, 0);
    op(1, 1, 0, 0, 8'h20, 8'h33, ERR_LOCKED, 8'h11, 1);
    op(1, 0, 0, 0, 8'h20, 8'h00, ERR_LOCKED, 8'h11, 1);
    op(2, 0, 0, 0, 8'h20, 8'h00, ERR_OK, 8'h77, 1);
    op(2, 0, 0, 1, 8'h00, 8'h00, ERR_OK, 8'h00, 0);
    check("lock_vld_freed", 32'(lock_vld), 32'h0);
    check("lock_own_freed", 32'(lock_own), 32'h0);
    op(1, 1, 0, 0, 8'h20, 8'h33, ERR_OK, 8'h00, 0);
    op(1, 0, 0, 0, 8'h20, 8'h00, ERR_OK, 8'h33, 1);

    // Range and illegal commands
    op(0, 0, 0, 0, 8'h80, 8'h00, ERR_RANGE, 8'h00, 1);
    op(0, 1, 0, 0, 8'h7F, 8'hC3, ERR_OK, 8'h00, 0);
    op(0, 0, 0, 0, 8'h7F, 8'h00, ERR_OK, 8'hC3, 1);
    op(3, 0, 0, 1, 8'h00, 8'h00, ERR_ILLEGAL, 8'h00, 0);
    op(0, 0, 1, 1, 8'h00, 8'h00, ERR_ILLEGAL, 8'hC3, 1);
    check("lock_vld_illegal", 32'(lock_vld), 32'h0);

    // Write granted on the edge just before a read of the same address
    exp_q.push_back('{0, ERR_OK, 8'h00, 1'b0});
    exp_q.push_back('{1, ERR_OK, 8'h99, 1'b1});
    cmd(0, 1, 0, 0, 8'h30);
    step();
    in_ad[0*DB +: DB] = 8'h99;
    step();
    cmd(1, 0, 0, 0, 8'h30);
    step();
    wait_idle();

    // Reset with port1 in WDAT and port2 owning the lock
    op(2, 0, 1, 0, 8'h00, 8'h00, ERR_OK, 8'h00, 0);
    cmd(1, 1, 0, 0, 8'h10);
    step();
    in_ad[1*DB +: DB] = 8'hEE;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst2_ack", 32'(ack), 32'hF);
    check("rst2_lock_vld", 32'(lock_vld), 32'h0);
    check("rst2_err", 32'(err), 32'h0);
    check("rst2_data", out_data, 32'h0);
    check("rst2_queue", 32'(exp_q.size()), 32'h0);
    op(0, 0, 0, 0, 8'h10, 8'h00, ERR_OK, 8'hA5, 1);
    op(0, 0, 0, 0, 8'h7F, 8'h00, ERR_OK, 8'hC3, 1);
    op(3, 0, 0, 0, 8'h30, 8'h00, ERR_OK, 8'h99, 1);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
